host_cmd_controller: RTL and testbench

//  Clock-domain host command decoder and memory-port arbiter between the SPI byte receiver and the processor memories.
//  - Decodes framed SPI command bytes.
//  - Packs streamed bytes into instruction, parameter and activation memory words.
//  - Serves activation-memory readback.
//  - Owns processor enable and soft reset; blocks host writes while the datapath owns the memories (proc_enable=1).

---
 rtl/dfctrl_pkg.sv | 29 ++
 rtl/byte_word_packer.sv | 58 +++++
 rtl/host_cmd_controller.sv | 209 ++++++++++++++++++++
 tb/tb_host_cmd_controller.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfctrl_pkg.sv
// Shared definitions for the host command controller: command headers,
// control opcodes and the frame decoder state type.
package dfctrl_pkg;

    localparam logic [1:0] HDR_CTRL  = 2'b00;
    localparam logic [1:0] HDR_PARAM = 2'b01;
    localparam logic [1:0] HDR_ACT   = 2'b10;
    localparam logic [1:0] HDR_INST  = 2'b11;

    localparam logic [7:0] CMD_DISABLE = 8'h0C;
    localparam logic [7:0] CMD_SRST    = 8'h0D;
    localparam logic [7:0] CMD_ENABLE  = 8'h0E;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_HI,
        ADDR_LO,
        WRITE,
        READ,
        DISCARD
    } state_t;

    // Mask that keeps the low 'width' bits of a 16-bit host address.
    function automatic logic [15:0] addr_mask(input int unsigned width);
        return 16'((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Byte-to-word shift register: packs WIDTH/8 bytes MSB-first and pulses
// o_word_valid for one cycle after the final byte of a word.
module byte_word_packer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [7:0]       i_byte,
    output logic [WIDTH-1:0] o_word,
    output logic             o_word_valid
);

    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_word;
    logic             r_word_valid;
    logic [WIDTH-1:0] w_shifted;
    logic             w_last;

    generate
        if (NBYTES > 1) begin : g_shift
            assign w_shifted = {r_word[WIDTH-9:0], i_byte};
        end else begin : g_single
            assign w_shifted = i_byte;
        end
    endgenerate

    assign w_last = (r_count == CW'(NBYTES - 1));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_count      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_count <= '0;
            end else if (i_valid) begin
                r_word <= w_shifted;
                if (w_last) begin
                    r_count      <= '0;
                    r_word_valid <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;

endmodule

// File: rtl/host_cmd_controller.sv
// Host command decoder: turns framed SPI bytes into memory writes, activation
// readback, processor enable and soft-reset control.
module host_cmd_controller
    import dfctrl_pkg::*;
#(
    parameter int unsigned WIDTH_ADDR_INST  = 6,
    parameter int unsigned WIDTH_INST_MEM   = 80,
    parameter int unsigned WIDTH_ADDR_PARAM = 13,
    parameter int unsigned WIDTH_PARAM_MEM  = 128,
    parameter int unsigned DEPTH_PARAM_MEM  = 7000,
    parameter int unsigned WIDTH_ADDR_ACT   = 12,
    parameter int unsigned WIDTH_ACT_MEM    = 8,
    parameter int unsigned SRST_CYCLES      = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        frame_active,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_byte,
    output logic [7:0]                  tx_byte,
    output logic                        tx_load,
    output logic                        inst_we,
    output logic [WIDTH_ADDR_INST-1:0]  inst_addr,
    output logic [WIDTH_INST_MEM-1:0]   inst_wdata,
    output logic                        param_we,
    output logic [WIDTH_ADDR_PARAM-1:0] param_addr,
    output logic [WIDTH_PARAM_MEM-1:0]  param_wdata,
    output logic                        act_we,
    output logic                        act_re,
    output logic [WIDTH_ADDR_ACT-1:0]   act_addr,
    output logic [WIDTH_ACT_MEM-1:0]    act_wdata,
    input  logic [WIDTH_ACT_MEM-1:0]    act_rdata,
    output logic                        proc_enable,
    output logic                        soft_reset_n,
    output logic                        cmd_error
);

    localparam int unsigned SRST_W = $clog2(SRST_CYCLES + 1);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_frame_d;
    logic [1:0]          r_hdr;
    logic                r_rd;
    logic [7:0]          r_addr_hi;
    logic [15:0]         r_addr;
    logic                r_proc_en;
    logic                r_err;
    logic [SRST_W-1:0]   r_srst_cnt;
    logic                r_act_re;
    logic                r_tx_load;
    logic [7:0]          r_tx_hold;

    logic                w_byte;
    logic                w_rise;
    logic [1:0]          w_cmd_hdr;
    logic                w_bad_read;
    logic [15:0]         w_addr_mask;
    logic [15:0]         w_addr_inc;
    logic                w_param_ok;
    logic                w_pack_clear;
    logic                w_inst_wv;
    logic                w_param_wv;
    logic                w_act_wv;
    logic                w_word_done;
    logic                w_wr_block;

    assign w_byte     = rx_valid & frame_active;
    assign w_rise     = frame_active & ~r_frame_d;
    assign w_cmd_hdr  = rx_byte[7:6];
    assign w_bad_read = rx_byte[5] & (w_cmd_hdr != HDR_ACT) & (w_cmd_hdr != HDR_CTRL);

    always_comb begin
        case (r_hdr)
            HDR_PARAM: w_addr_mask = addr_mask(WIDTH_ADDR_PARAM);
            HDR_ACT:   w_addr_mask = addr_mask(WIDTH_ADDR_ACT);
            default:   w_addr_mask = addr_mask(WIDTH_ADDR_INST);
        endcase
    end

    assign w_addr_inc  = (r_addr + 16'd1) & w_addr_mask;
    assign w_param_ok  = (32'(r_addr) < DEPTH_PARAM_MEM);
    assign w_word_done = w_inst_wv | w_param_wv | w_act_wv;
    assign w_wr_block  = r_proc_en | (w_param_wv & ~w_param_ok);

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (!frame_active) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_rise) w_next_state = CMD;
                CMD:     if (w_byte) w_next_state = (w_cmd_hdr == HDR_CTRL || w_bad_read) ? DISCARD : ADDR_HI;
                ADDR_HI: if (w_byte) w_next_state = ADDR_LO;
                ADDR_LO: if (w_byte) w_next_state = r_rd ? READ : WRITE;
                default: w_next_state = r_state;
            endcase
        end
    end

    // r_frame_d resets high so a frame already in progress at reset release
    // never produces a rising edge and is ignored until frame_active falls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_frame_d  <= 1'b1;
            r_hdr      <= '0;
            r_rd       <= 1'b0;
            r_addr_hi  <= '0;
            r_addr     <= '0;
            r_proc_en  <= 1'b0;
            r_err      <= 1'b0;
            r_srst_cnt <= '0;
            r_act_re   <= 1'b0;
            r_tx_load  <= 1'b0;
            r_tx_hold  <= '0;
        end else begin
            r_frame_d <= frame_active;
            r_act_re  <= 1'b0;
            r_tx_load <= r_act_re;
            if (r_tx_load) r_tx_hold <= act_rdata;
            if (r_srst_cnt != '0) r_srst_cnt <= r_srst_cnt - 1'b1;
            if (r_act_re) r_addr <= w_addr_inc;
            if (w_word_done) begin
                if (w_wr_block) r_err <= 1'b1;
                r_addr <= w_addr_inc;
            end
            if (w_byte) begin
                case (r_state)
                    CMD: begin
                        r_hdr <= w_cmd_hdr;
                        r_rd  <= rx_byte[5];
                        if (w_cmd_hdr == HDR_CTRL) begin
                            case (rx_byte)
                                CMD_DISABLE: r_proc_en <= 1'b0;
                                CMD_ENABLE:  r_proc_en <= 1'b1;
                                CMD_SRST: begin
                                    r_srst_cnt <= SRST_W'(SRST_CYCLES);
                                    r_err      <= 1'b0;
                                end
                                default:     r_err <= 1'b1;
                            endcase
                        end else if (w_bad_read) begin
                            r_err <= 1'b1;
                        end
                    end
                    ADDR_HI: r_addr_hi <= rx_byte;
                    ADDR_LO: begin
                        r_addr <= {r_addr_hi, rx_byte} & w_addr_mask;
                        if (r_rd) r_act_re <= 1'b1;
                    end
                    READ:    r_act_re <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign w_pack_clear = (r_state != WRITE);

    byte_word_packer #(.WIDTH(WIDTH_INST_MEM)) u_inst_packer (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_clear      (w_pack_clear),
        .i_valid      (w_byte && r_state == WRITE && r_hdr == HDR_INST),
        .i_byte       (rx_byte),
        .o_word       (inst_wdata),
        .o_word_valid (w_inst_wv)
    );

    byte_word_packer #(.WIDTH(WIDTH_PARAM_MEM)) u_param_packer (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_clear      (w_pack_clear),
        .i_valid      (w_byte && r_state == WRITE && r_hdr == HDR_PARAM),
        .i_byte       (rx_byte),
        .o_word       (param_wdata),
        .o_word_valid (w_param_wv)
    );

    byte_word_packer #(.WIDTH(WIDTH_ACT_MEM)) u_act_packer (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_clear      (w_pack_clear),
        .i_valid      (w_byte && r_state == WRITE && r_hdr == HDR_ACT),
        .i_byte       (rx_byte),
        .o_word       (act_wdata),
        .o_word_valid (w_act_wv)
    );

    assign inst_we      = w_inst_wv & ~r_proc_en;
    assign param_we     = w_param_wv & ~r_proc_en & w_param_ok;
    assign act_we       = w_act_wv & ~r_proc_en;
    assign inst_addr    = r_addr[WIDTH_ADDR_INST-1:0];
    assign param_addr   = r_addr[WIDTH_ADDR_PARAM-1:0];
    assign act_addr     = r_addr[WIDTH_ADDR_ACT-1:0];
    assign act_re       = r_act_re;
    assign tx_load      = r_tx_load;
    // Read data arrives in the tx_load cycle itself; hold it afterwards.
    assign tx_byte      = r_tx_load ? act_rdata : r_tx_hold;
    assign proc_enable  = r_proc_en;
    assign cmd_error    = r_err;
    assign soft_reset_n = (r_srst_cnt == '0);

endmodule

// File: tb/tb_host_cmd_controller.sv
// Randomised and directed frames checked against a frame-level reference
// model of the host command protocol.
module tb_host_cmd_controller;

    localparam int unsigned SRST_CYCLES = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         frame_active;
    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic [7:0]   tx_byte;
    logic         tx_load;
    logic         inst_we;
    logic [5:0]   inst_addr;
    logic [79:0]  inst_wdata;
    logic         param_we;
    logic [12:0]  param_addr;
    logic [127:0] param_wdata;
    logic         act_we;
    logic         act_re;
    logic [11:0]  act_addr;
    logic [7:0]   act_wdata;
    logic [7:0]   act_rdata;
    logic         proc_enable;
    logic         soft_reset_n;
    logic         cmd_error;

    always #5 clk = ~clk;

    host_cmd_controller #(
        .WIDTH_ADDR_INST  (6),
        .WIDTH_INST_MEM   (80),
        .WIDTH_ADDR_PARAM (13),
        .WIDTH_PARAM_MEM  (128),
        .DEPTH_PARAM_MEM  (7000),
        .WIDTH_ADDR_ACT   (12),
        .WIDTH_ACT_MEM    (8),
        .SRST_CYCLES      (SRST_CYCLES)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_active (frame_active),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .tx_byte      (tx_byte),
        .tx_load      (tx_load),
        .inst_we      (inst_we),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .param_we     (param_we),
        .param_addr   (param_addr),
        .param_wdata  (param_wdata),
        .act_we       (act_we),
        .act_re       (act_re),
        .act_addr     (act_addr),
        .act_wdata    (act_wdata),
        .act_rdata    (act_rdata),
        .proc_enable  (proc_enable),
        .soft_reset_n (soft_reset_n),
        .cmd_error    (cmd_error)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 73 + 29) ^ (i >> 4));
    endfunction

    // Activation memory seen by the DUT: synchronous read, one cycle latency.
    logic [7:0] env_mem [4096];
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4096; i++) env_mem[i] <= init_val(i);
            act_rdata <= '0;
        end else begin
            if (act_we) env_mem[act_addr] <= act_wdata;
            if (act_re) act_rdata <= env_mem[act_addr];
        end
    end

    typedef struct packed {
        logic [1:0]   tgt;
        logic [15:0]  addr;
        logic [127:0] data;
    } wr_t;

    wr_t        obs_wr[$];
    wr_t        exp_wr[$];
    logic [7:0] obs_tx[$];
    logic [7:0] exp_tx[$];
    int         obs_srst[$];
    int         exp_srst_n;
    int         srst_run;
    logic [7:0] mdl_act [4096];
    bit         m_en;
    bit         m_err;
    int         n_tests;
    int         n_fail;

    always @(negedge clk) begin
        if (inst_we)  obs_wr.push_back('{2'b11, 16'(inst_addr), 128'(inst_wdata)});
        if (param_we) obs_wr.push_back('{2'b01, 16'(param_addr), param_wdata});
        if (act_we)   obs_wr.push_back('{2'b10, 16'(act_addr), 128'(act_wdata)});
        if (tx_load)  obs_tx.push_back(tx_byte);
        if (!soft_reset_n) begin
            srst_run++;
        end else if (srst_run != 0) begin
            obs_srst.push_back(srst_run);
            srst_run = 0;
        end
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: applies one complete frame's effective bytes.
    task automatic model_frame(input logic [7:0] b[$]);
        int n, aw, nb, a, nw;
        logic [7:0]   cmd;
        logic [127:0] data;
        n = b.size();
        if (n == 0) return;
        cmd = b[0];
        if (cmd[7:6] == 2'b00) begin
            if (cmd == 8'h0C) m_en = 1'b0;
            else if (cmd == 8'h0E) m_en = 1'b1;
            else if (cmd == 8'h0D) begin m_err = 1'b0; exp_srst_n++; end
            else m_err = 1'b1;
            return;
        end
        if (cmd[5] && cmd[7:6] != 2'b10) begin
            m_err = 1'b1;
            return;
        end
        if (n < 3) return;
        aw = (cmd[7:6] == 2'b01) ? 13 : (cmd[7:6] == 2'b10) ? 12 : 6;
        nb = (cmd[7:6] == 2'b01) ? 16 : (cmd[7:6] == 2'b10) ? 1 : 10;
        a  = (int'(b[1]) * 256 + int'(b[2])) % (1 << aw);
        if (cmd[5]) begin
            for (int i = 2; i < n; i++) begin
                exp_tx.push_back(mdl_act[a]);
                a = (a + 1) % 4096;
            end
        end else begin
            nw = (n - 3) / nb;
            for (int w = 0; w < nw; w++) begin
                data = '0;
                for (int k = 0; k < nb; k++) data = (data << 8) | 128'(b[3 + w * nb + k]);
                if (m_en || (cmd[7:6] == 2'b01 && a >= 7000)) begin
                    m_err = 1'b1;
                end else begin
                    exp_wr.push_back('{cmd[7:6], 16'(a), data});
                    if (cmd[7:6] == 2'b10) mdl_act[a] = data[7:0];
                end
                a = (a + 1) % (1 << aw);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit with_fall);
        if (with_fall) frame_active = 1'b0;
        rx_byte  = v;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        if (!with_fall) repeat (16 + $urandom_range(0, 4)) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] b[$], input bit drop_last);
        logic [7:0] eff[$];
        eff = b;
        if (drop_last && eff.size() > 0) void'(eff.pop_back());
        model_frame(eff);
        @(negedge clk);
        frame_active = 1'b1;
        repeat (4) @(negedge clk);
        foreach (b[i]) send_byte(b[i], drop_last && (i == b.size() - 1));
        frame_active = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic compare_frame(input string tag);
        int nw;
        int nt;
        check({tag, ":n_writes"}, 160'(obs_wr.size()), 160'(exp_wr.size()));
        nw = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
        for (int i = 0; i < nw; i++) begin
            check({tag, ":wr_tgt_addr"}, 160'({obs_wr[i].tgt, obs_wr[i].addr}), 160'({exp_wr[i].tgt, exp_wr[i].addr}));
            check({tag, ":wr_data"}, 160'(obs_wr[i].data), 160'(exp_wr[i].data));
        end
        check({tag, ":n_tx"}, 160'(obs_tx.size()), 160'(exp_tx.size()));
        nt = (obs_tx.size() < exp_tx.size()) ? obs_tx.size() : exp_tx.size();
        for (int i = 0; i < nt; i++) check({tag, ":tx_byte"}, 160'(obs_tx[i]), 160'(exp_tx[i]));
        check({tag, ":n_srst"}, 160'(obs_srst.size()), 160'(exp_srst_n));
        foreach (obs_srst[i]) check({tag, ":srst_len"}, 160'(obs_srst[i]), 160'(SRST_CYCLES));
        check({tag, ":proc_enable"}, 160'(proc_enable), 160'(m_en));
        check({tag, ":cmd_error"}, 160'(cmd_error), 160'(m_err));
        obs_wr.delete(); exp_wr.delete(); obs_tx.delete(); exp_tx.delete(); obs_srst.delete();
        exp_srst_n = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":ctl"}, 160'({tx_byte, tx_load, inst_we, param_we, act_we, act_re,
                                   proc_enable, soft_reset_n, cmd_error}), 160'(2));
        check({tag, ":inst"}, 160'({inst_addr, inst_wdata}), '0);
        check({tag, ":param"}, 160'({param_addr, param_wdata}), '0);
        check({tag, ":act"}, 160'({act_addr, act_wdata}), '0);
    endtask

    task automatic model_reset();
        m_en = 1'b0;
        m_err = 1'b0;
        for (int i = 0; i < 4096; i++) mdl_act[i] = init_val(i);
    endtask

    task automatic random_frame(input int idx);
        logic [7:0] b[$];
        int kind, nbytes, a;
        kind = $urandom_range(0, 9);
        case (kind)
            0: b.push_back(($urandom_range(0, 1) == 1) ? 8'h0D : 8'($urandom_range(0, 63)));
            1, 2: begin b.push_back(8'h80 | 8'($urandom_range(0, 31) & 8'h1F)); nbytes = $urandom_range(0, 6); end
            3: begin b.push_back(8'hC0 | 8'($urandom_range(0, 31))); nbytes = $urandom_range(0, 25); end
            4: begin b.push_back(8'h40 | 8'($urandom_range(0, 31))); nbytes = $urandom_range(0, 35); end
            5, 6: begin b.push_back(8'hA0); nbytes = $urandom_range(0, 5); end
            7: b.push_back(($urandom_range(0, 1) == 1) ? 8'h60 : 8'hE0);
            8: b.push_back(($urandom_range(0, 2) == 0) ? 8'h0E : 8'h0C);
            default: begin b.push_back(8'($urandom)); nbytes = -2 + $urandom_range(0, 1); end
        endcase
        if (kind >= 1 && kind <= 6) begin
            a = (kind == 4 && $urandom_range(0, 1) == 1) ? 6998 + $urandom_range(0, 3) : int'($urandom_range(0, 65535));
            b.push_back(8'(a >> 8));
            b.push_back(8'(a));
            for (int i = 0; i < nbytes; i++) b.push_back(8'($urandom));
        end else if (kind == 9 && nbytes == -1) begin
            b.push_back(8'($urandom));
        end
        run_frame(b, $urandom_range(0, 7) == 0);
        compare_frame($sformatf("rand%0d", idx));
    endtask

    initial begin
        n_tests = 0; n_fail = 0; exp_srst_n = 0; srst_run = 0;
        reset_n = 1'b0; frame_active = 1'b0; rx_valid = 1'b0; rx_byte = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame('{8'h0E}, 1'b0);               compare_frame("enable");
        run_frame('{8'h0C}, 1'b0);               compare_frame("disable");
        run_frame('{8'h3F}, 1'b0);               compare_frame("bad_ctrl");
        run_frame('{8'h0D}, 1'b0);               compare_frame("srst");
        run_frame('{8'hC0, 8'h00, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                    8'h06, 8'h07, 8'h08, 8'h09, 8'h0A}, 1'b0);
        compare_frame("inst_wr");
        run_frame('{8'h80, 8'h0F, 8'hFF, 8'hAA, 8'hBB}, 1'b0);
        compare_frame("act_wrap");
        run_frame('{8'h0E}, 1'b0);               compare_frame("enable2");
        run_frame('{8'h80, 8'h00, 8'h00, 8'h55}, 1'b0);
        compare_frame("act_wr_blocked");
        run_frame('{8'hA0, 8'h00, 8'h00, 8'h3C}, 1'b0);
        compare_frame("act_read");
        run_frame('{8'h0C}, 1'b0);               compare_frame("disable2");
        run_frame('{8'h0D}, 1'b0);               compare_frame("srst2");
        begin
            logic [7:0] pb[$];
            pb = '{8'h40, 8'h1B, 8'h57};
            for (int i = 0; i < 32; i++) pb.push_back(8'(i * 5 + 1));
            run_frame(pb, 1'b0);                 compare_frame("param_6999_7000");
            pb = '{8'h40, 8'h1B, 8'h58};
            for (int i = 0; i < 16; i++) pb.push_back(8'(i));
            run_frame(pb, 1'b0);                 compare_frame("param_7000");
        end
        run_frame('{8'h0D}, 1'b0);               compare_frame("srst3");
        run_frame('{8'h40, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44}, 1'b0);
        compare_frame("param_partial");
        run_frame('{8'h80, 8'h01, 8'h00, 8'h12, 8'h34}, 1'b1);
        compare_frame("drop_on_fall");

        // Reset in the middle of a frame; the rest of that frame is ignored.
        run_frame('{8'h0E}, 1'b0);               compare_frame("enable3");
        @(negedge clk);
        frame_active = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'h80, 1'b0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("mid_reset");
        reset_n = 1'b1;
        model_reset();
        send_byte(8'h0E, 1'b0);
        send_byte(8'h00, 1'b0);
        frame_active = 1'b0;
        repeat (8) @(negedge clk);
        compare_frame("after_mid_reset");

        for (int i = 0; i < 30; i++) random_frame(i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
